// File: rtl/plx_hk_if.sv
// Signal bundle between the PLX local-bus housekeeping target and its environment.
// The slave modport is the target's view. The master modport is the bus master plus the register bank.
interface plx_hk_if;
    logic        nADS_i;
    logic        nCS_i;
    logic        WnR_i;
    logic [5:0]  LA_i;
    logic [31:0] LD_i;
    logic [31:0] LD_o;
    logic        LD_oe_o;
    logic        nREADY_o;
    logic        nBTERM_o;
    logic [5:0]  reg_addr_o;
    logic [31:0] reg_dat_o;
    logic        reg_wr_o;
    logic        reg_rd_o;
    logic [31:0] reg_dat_i;
    logic        reg_ack_i;
    logic        timeout_o;

    modport slave (
        input  nADS_i, nCS_i, WnR_i, LA_i, LD_i, reg_dat_i, reg_ack_i,
        output LD_o, LD_oe_o, nREADY_o, nBTERM_o, reg_addr_o, reg_dat_o,
        output reg_wr_o, reg_rd_o, timeout_o
    );

    modport master (
        output nADS_i, nCS_i, WnR_i, LA_i, LD_i, reg_dat_i, reg_ack_i,
        input  LD_o, LD_oe_o, nREADY_o, nBTERM_o, reg_addr_o, reg_dat_o,
        input  reg_wr_o, reg_rd_o, timeout_o
    );
endinterface

// File: rtl/plx_hk_target.sv
// Single-beat PLX local-bus target for the housekeeping window.
// Each bus cycle becomes one strobe on the register-bank port, and nREADY completes the cycle.
//   state | meaning
//   IDLE  | waiting for nADS with nCS low
//   REQ   | strobe cycle; write data is sampled from LD
//   WAIT  | waiting for reg_ack_i, or for the timeout terminal count
//   READY | nREADY low for one cycle; LD is driven on reads
//   HOLD  | waiting for nCS to go high before another cycle is accepted
module plx_hk_target #(
    parameter int          TIMEOUT      = 16,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
    input  logic     clk_i,
    input  logic     rst_i,
    plx_hk_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] READY = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          is_wr;

    // The strobe is issued on the edge that enters REQ. The write data is taken on the edge that leaves REQ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            is_wr          <= 1'b0;
            bus.LD_o       <= '0;
            bus.LD_oe_o    <= 1'b0;
            bus.nREADY_o   <= 1'b1;
            bus.nBTERM_o   <= 1'b1;
            bus.reg_addr_o <= '0;
            bus.reg_dat_o  <= '0;
            bus.reg_wr_o   <= 1'b0;
            bus.reg_rd_o   <= 1'b0;
            bus.timeout_o  <= 1'b0;
        end else begin
            bus.reg_rd_o  <= 1'b0;
            bus.reg_wr_o  <= 1'b0;
            bus.timeout_o <= 1'b0;
            bus.nREADY_o  <= 1'b1;
            bus.LD_oe_o   <= 1'b0;
            bus.nBTERM_o  <= 1'b1;
            case (state)
                IDLE: begin
                    if (!bus.nADS_i && !bus.nCS_i) begin
                        bus.reg_addr_o <= bus.LA_i;
                        is_wr          <= bus.WnR_i;
                        bus.reg_rd_o   <= !bus.WnR_i;
                        bus.reg_wr_o   <= bus.WnR_i;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (is_wr)
                        bus.reg_dat_o <= bus.LD_i;
                    if (bus.nCS_i) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CW'(TIMEOUT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // An abort has priority over an ack that arrives in the same cycle.
                    if (bus.nCS_i) begin
                        state <= IDLE;
                    end else if (bus.reg_ack_i) begin
                        if (!is_wr)
                            bus.LD_o <= bus.reg_dat_i;
                        bus.nREADY_o <= 1'b0;
                        bus.LD_oe_o  <= !is_wr;
                        state        <= READY;
                    end else if (cnt == '0) begin
                        if (!is_wr)
                            bus.LD_o <= TIMEOUT_DATA;
                        bus.timeout_o <= 1'b1;
                        bus.nREADY_o  <= 1'b0;
                        bus.LD_oe_o   <= !is_wr;
                        state         <= READY;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READY: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (bus.nCS_i)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plx_hk_target.sv
// Directed bench for plx_hk_target. The stimulus queues the expected strobes, ready pulses and timeouts.
// A negedge monitor pops each expectation and compares it when the DUT shows the event.
module tb_plx_hk_target;
    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } strobe_t;

    typedef struct {
        int          cyc;
        bit          oe;
        logic [31:0] data;
    } ready_t;

    logic clk;
    logic rst;
    plx_hk_if bus ();

    plx_hk_target dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    strobe_t strobe_q[$];
    ready_t  ready_q[$];
    int      tmo_q[$];
    int          ack_delay = -1;
    logic [31:0] ack_data = '0;
    bit          wr_pending = 0;
    logic [31:0] wr_exp = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register-bank model: acks a strobe ack_delay cycles after the strobe cycle.
    initial begin
        bus.reg_ack_i = 1'b0;
        bus.reg_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((bus.reg_rd_o || bus.reg_wr_o) && ack_delay >= 0) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                bus.reg_ack_i = 1'b1;
                bus.reg_dat_i = ack_data;
                @(posedge clk);
                #1;
                bus.reg_ack_i = 1'b0;
                bus.reg_dat_i = '0;
            end
        end
    end

    initial begin
        strobe_t s;
        ready_t  r;
        int      t;
        forever begin
            @(negedge clk);
            if (wr_pending) begin
                chk("wr_data", bus.reg_dat_o, wr_exp);
                wr_pending = 0;
            end
            if (bus.reg_rd_o || bus.reg_wr_o) begin
                if (strobe_q.size() == 0) begin
                    chk("unexpected_strobe", {26'd0, bus.reg_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    s = strobe_q.pop_front();
                    chk("strobe_kind", {30'd0, bus.reg_wr_o, bus.reg_rd_o}, {30'd0, s.wr, !s.wr});
                    chk("strobe_addr", {26'd0, bus.reg_addr_o}, {26'd0, s.addr});
                    if (s.wr) begin
                        wr_pending = 1;
                        wr_exp     = s.data;
                    end
                end
            end
            if (bus.nREADY_o === 1'b0) begin
                if (ready_q.size() == 0) begin
                    chk("unexpected_nready", 32'd0, 32'd1);
                end else begin
                    r = ready_q.pop_front();
                    chk("ready_cycle", cyc, r.cyc);
                    chk("ready_oe", {31'd0, bus.LD_oe_o}, {31'd0, r.oe});
                    if (r.oe) chk("ready_data", bus.LD_o, r.data);
                end
            end
            if (bus.timeout_o === 1'b1) begin
                if (tmo_q.size() == 0) begin
                    chk("unexpected_timeout", 32'd1, 32'd0);
                end else begin
                    t = tmo_q.pop_front();
                    chk("timeout_cycle", cyc, t);
                end
            end
            if (bus.LD_oe_o === 1'b1 && bus.nREADY_o !== 1'b0)
                chk("stray_oe", 32'd1, 32'd0);
        end
    end

    // Called at #1 after a posedge with nCS high. A negative dly means the bank never acks.
    task automatic bus_cycle(input bit wr, input logic [5:0] addr, input logic [31:0] wdata,
                             input int dly, input logic [31:0] rdata,
                             input bit abort, input bit extra_ads);
        int n;
        int k;
        ack_delay = dly;
        ack_data  = rdata;
        bus.nADS_i = 1'b0;
        bus.nCS_i  = 1'b0;
        bus.WnR_i  = wr;
        bus.LA_i   = addr;
        strobe_q.push_back('{wr, addr, wdata});
        @(posedge clk);
        #1;
        n = cyc;
        bus.nADS_i = 1'b1;
        bus.LD_i   = wdata;
        if (abort) begin
            @(posedge clk);
            #1;
            bus.nCS_i = 1'b1;
            repeat (8) @(posedge clk);
            #1;
        end else begin
            if (dly < 0) begin
                tmo_q.push_back(n + 17);
                ready_q.push_back('{n + 17, !wr, 32'hDEADDEAD});
            end else begin
                ready_q.push_back('{n + 1 + dly, !wr, rdata});
            end
            k = 0;
            while (bus.nREADY_o !== 1'b0 && k < 40) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (k >= 40) chk("nready_wait", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            if (extra_ads) begin
                bus.nADS_i = 1'b0;
                bus.LA_i   = 6'h3E;
                @(posedge clk);
                #1;
                bus.nADS_i = 1'b1;
                @(posedge clk);
                #1;
            end
            bus.nCS_i = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.nADS_i = 1'b1;
        bus.nCS_i  = 1'b1;
        bus.WnR_i  = 1'b0;
        bus.LA_i   = '0;
        bus.LD_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_LD_o", bus.LD_o, 32'd0);
        chk("rst_LD_oe", {31'd0, bus.LD_oe_o}, 32'd0);
        chk("rst_nREADY", {31'd0, bus.nREADY_o}, 32'd1);
        chk("rst_nBTERM", {31'd0, bus.nBTERM_o}, 32'd1);
        chk("rst_reg_addr", {26'd0, bus.reg_addr_o}, 32'd0);
        chk("rst_reg_dat", bus.reg_dat_o, 32'd0);
        chk("rst_strobes", {30'd0, bus.reg_wr_o, bus.reg_rd_o}, 32'd0);
        chk("rst_timeout", {31'd0, bus.timeout_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // nADS without chip select is ignored.
        bus.nADS_i = 1'b0;
        @(posedge clk);
        #1;
        bus.nADS_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        bus_cycle(1'b0, 6'h03, 32'h0, 1, 32'h53555246, 1'b0, 1'b0);
        bus_cycle(1'b1, 6'h05, 32'h0000ABCD, 2, 32'h0, 1'b0, 1'b0);
        bus_cycle(1'b0, 6'h3F, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            bus_cycle(1'b0, 6'(i), 32'h0, 1, 32'h1000_0000 + 32'(i * 3), 1'b0, (i == 3));
        bus_cycle(1'b0, 6'h11, 32'h0, 3, 32'hBAD0BAD0, 1'b1, 1'b0);
        bus_cycle(1'b0, 6'h12, 32'h0, 1, 32'hCAFE0012, 1'b0, 1'b0);

        // Reset while the target is waiting for an ack that never comes.
        ack_delay  = -1;
        bus.nADS_i = 1'b0;
        bus.nCS_i  = 1'b0;
        bus.WnR_i  = 1'b0;
        bus.LA_i   = 6'h2A;
        strobe_q.push_back('{1'b0, 6'h2A, 32'h0});
        @(posedge clk);
        #1;
        bus.nADS_i = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_LD_oe", {31'd0, bus.LD_oe_o}, 32'd0);
        chk("mid_rst_nREADY", {31'd0, bus.nREADY_o}, 32'd1);
        chk("mid_rst_LD_o", bus.LD_o, 32'd0);
        chk("mid_rst_reg_addr", {26'd0, bus.reg_addr_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.nCS_i = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        chk("strobes_left", strobe_q.size(), 32'd0);
        chk("readies_left", ready_q.size(), 32'd0);
        chk("timeouts_left", tmo_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
